// File: rtl/cipher_uart_tx.sv
// cipher_uart_tx
//   Streaming encrypt-and-transmit block. Plaintext bytes arrive over a
//   valid/ready handshake. Each byte is encrypted with one of four key modes
//   (bypass, static XOR, rotating XOR, chained XOR). The ciphertext is
//   buffered in a FIFO and sent out as 8N1 UART frames.
// Ports:
//   i_Clock, i_Reset          clock, synchronous active-high reset
//   i_Start, i_Mode, i_Key,   load mode/key/shift and reload the working key
//   i_Shift
//   i_Data_Valid, i_Data,     plaintext byte stream with end-of-message tag
//   i_Last, o_Data_Ready
//   o_TX_Serial, o_TX_Active  UART line (idle high), frame-in-progress flag
//   o_Done                    one-cycle pulse in the final stop cycle of a
//                             byte tagged last
//   o_Fifo_Count              ciphertext FIFO occupancy
module cipher_uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Start,
  input  logic [1:0]                    i_Mode,
  input  logic [7:0]                    i_Key,
  input  logic [2:0]                    i_Shift,
  input  logic                          i_Data_Valid,
  input  logic [7:0]                    i_Data,
  input  logic                          i_Last,
  output logic                          o_Data_Ready,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_CNT = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_STATIC = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_CHAIN  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // ---------------- key schedule ----------------
  mode_t       r_mode;
  logic [7:0]  r_k0;
  logic [2:0]  r_shift;
  logic [7:0]  r_kw;
  logic [7:0]  w_cipher;
  logic [15:0] w_rot16;
  logic [7:0]  w_rot;
  logic        w_full;
  logic        w_push;
  logic        w_pop;

  // Rotate via a doubled word so a shift of 0 needs no special case.
  assign w_rot16 = {r_kw, r_kw} << r_shift;
  assign w_rot   = w_rot16[15:8];

  always_comb begin
    w_cipher = i_Data;
    case (r_mode)
      MODE_STATIC:             w_cipher = i_Data ^ r_k0;
      MODE_ROTATE, MODE_CHAIN: w_cipher = i_Data ^ r_kw;
      default:                 w_cipher = i_Data;
    endcase
  end

  assign o_Data_Ready = !w_full && !i_Reset;
  assign w_push       = i_Data_Valid && o_Data_Ready;

  // The i_Start load comes last so it overrides a same-edge key update,
  // while the byte on that edge is still encrypted with the old state.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_mode  <= MODE_BYPASS;
      r_k0    <= '0;
      r_shift <= '0;
      r_kw    <= '0;
    end else begin
      if (w_push) begin
        case (r_mode)
          MODE_ROTATE: r_kw <= w_rot;
          MODE_CHAIN:  r_kw <= w_cipher;
          default:     ;
        endcase
      end
      if (i_Start) begin
        r_mode  <= mode_t'(i_Mode);
        r_k0    <= i_Key;
        r_shift <= i_Shift;
        r_kw    <= i_Key;
      end
    end
  end

  // ---------------- ciphertext FIFO ----------------
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  tx_state_t     r_state;

  assign w_full       = (r_count == FULL_CNT);
  assign w_pop        = (r_state == ST_IDLE) && (r_count != '0);
  assign o_Fifo_Count = r_count;

  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_Last, w_cipher};
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // ---------------- UART transmitter ----------------
  logic [7:0]    r_tx_shift;
  logic          r_tx_last;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state     <= ST_IDLE;
      r_tx_shift  <= '0;
      r_tx_last   <= 1'b0;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
          o_Done      <= 1'b0;
          r_clk_cnt   <= '0;
          if (w_pop) begin
            {r_tx_last, r_tx_shift} <= r_mem[r_rd_ptr];
            r_state     <= ST_START;
            o_TX_Serial <= 1'b0;
            o_TX_Active <= 1'b1;
          end
        end
        ST_START: begin
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_state     <= ST_DATA;
            o_TX_Serial <= r_tx_shift[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state     <= ST_STOP;
              o_TX_Serial <= 1'b1;
            end else begin
              r_bit_idx   <= r_bit_idx + 1'b1;
              r_tx_shift  <= r_tx_shift >> 1;
              o_TX_Serial <= r_tx_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Registered pulse: raised on the edge entering the final stop cycle.
          o_Done <= r_tx_last && (r_clk_cnt == DONE_CNT);
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt   <= '0;
            r_state     <= ST_IDLE;
            o_TX_Active <= 1'b0;
            o_Done      <= 1'b0;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_uart_tx.sv
module tb_cipher_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Start = 1'b0;
  logic [1:0] i_Mode = '0;
  logic [7:0] i_Key = '0;
  logic [2:0] i_Shift = '0;
  logic       i_Data_Valid = 1'b0;
  logic [7:0] i_Data = '0;
  logic       i_Last = 1'b0;
  logic       o_Data_Ready;
  logic       o_TX_Serial;
  logic       o_TX_Active;
  logic       o_Done;
  logic [2:0] o_Fifo_Count;

  int ncomp = 0;
  int nfail = 0;
  int cyc = 0;

  logic [7:0] rx_data[$];
  logic       rx_stop[$];
  int         rx_start[$];
  int         done_cyc[$];

  cipher_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Mode(i_Mode),
    .i_Key(i_Key), .i_Shift(i_Shift), .i_Data_Valid(i_Data_Valid),
    .i_Data(i_Data), .i_Last(i_Last), .o_Data_Ready(o_Data_Ready),
    .o_TX_Serial(o_TX_Serial), .o_TX_Active(o_TX_Active), .o_Done(o_Done),
    .o_Fifo_Count(o_Fifo_Count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent UART receiver: samples mid-bit, records frames and o_Done.
  initial begin
    int ph;
    bit busy;
    logic [7:0] sh;
    ph = 0; busy = 0; sh = '0;
    forever begin
      @(posedge clk); #3;
      if (o_Done === 1'b1) done_cyc.push_back(cyc);
      if (i_Reset) busy = 0;
      else if (!busy) begin
        if (o_TX_Serial === 1'b0) begin
          busy = 1; ph = 0; rx_start.push_back(cyc);
        end
      end else begin
        ph++;
        for (int i = 0; i < 8; i++)
          if (ph == CPB * (i + 1) + CPB / 2) sh[i] = o_TX_Serial;
        if (ph == 9 * CPB + CPB / 2) begin
          rx_data.push_back(sh);
          rx_stop.push_back(o_TX_Serial);
        end
        if (ph == 10 * CPB - 1) busy = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    rx_data.delete(); rx_stop.delete(); rx_start.delete(); done_cyc.delete();
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [7:0] k, input logic [2:0] s);
    i_Start = 1'b1; i_Mode = m; i_Key = k; i_Shift = s;
    tick();
    i_Start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int k;
    i_Data_Valid = 1'b1; i_Data = d; i_Last = l; k = 0;
    while (!o_Data_Ready && k < 1000) begin tick(); k++; end
    tick();
    i_Data_Valid = 1'b0; i_Last = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string nm);
    int k;
    k = 0;
    while (rx_data.size() < n && k < 2000) begin tick(); k++; end
    ncomp++;
    if (rx_data.size() < n) begin
      nfail++;
      $display("FAIL %s_timeout: frames got %0d required %0d", nm, rx_data.size(), n);
    end
  endtask

  task automatic idle_wait();
    int k;
    k = 0;
    while ((o_TX_Active !== 1'b0 || o_Fifo_Count !== 3'd0) && k < 2000) begin tick(); k++; end
    tick();
  endtask

  task automatic check_frames(input string nm, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      logic [7:0] got;
      logic       stp;
      got = (rx_data.size() > i) ? rx_data[i] : 8'hxx;
      stp = (rx_stop.size() > i) ? rx_stop[i] : 1'bx;
      ncomp++;
      if (got !== exp[i]) begin
        nfail++;
        $display("FAIL %s_byte%0d: got %02h required %02h", nm, i, got, exp[i]);
      end
      ncomp++;
      if (stp !== 1'b1) begin
        nfail++;
        $display("FAIL %s_stop%0d: got %b required 1", nm, i, stp);
      end
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    repeat (3) tick();
    ncomp++; if (o_TX_Serial !== 1'b1) begin nfail++; $display("FAIL rst_serial: got %b required 1", o_TX_Serial); end
    ncomp++; if (o_TX_Active !== 1'b0) begin nfail++; $display("FAIL rst_active: got %b required 0", o_TX_Active); end
    ncomp++; if (o_Done !== 1'b0) begin nfail++; $display("FAIL rst_done: got %b required 0", o_Done); end
    ncomp++; if (o_Fifo_Count !== 3'd0) begin nfail++; $display("FAIL rst_count: got %0d required 0", o_Fifo_Count); end
    ncomp++; if (o_Data_Ready !== 1'b0) begin nfail++; $display("FAIL rst_ready_in_reset: got %b required 0", o_Data_Ready); end
    i_Reset = 1'b0;
    tick();
    ncomp++; if (o_Data_Ready !== 1'b1) begin nfail++; $display("FAIL rst_ready_after: got %b required 1", o_Data_Ready); end
  endtask

  task automatic test_static();
    clear_q();
    pulse_start(2'b01, 8'h80, 3'd0);
    push(8'h61, 1'b1);
    wait_rx(1, "static");
    idle_wait();
    check_frames("static", '{8'hE1});
    ncomp++;
    if (done_cyc.size() !== 1) begin
      nfail++; $display("FAIL static_done_count: got %0d required 1", done_cyc.size());
    end else begin
      ncomp++;
      if (done_cyc[0] !== rx_start[0] + 10 * CPB - 1) begin
        nfail++; $display("FAIL static_done_time: got %0d required %0d", done_cyc[0], rx_start[0] + 10 * CPB - 1);
      end
    end
    ncomp++; if (o_TX_Active !== 1'b0) begin nfail++; $display("FAIL static_active_after: got %b required 0", o_TX_Active); end
    ncomp++; if (o_TX_Serial !== 1'b1) begin nfail++; $display("FAIL static_line_after: got %b required 1", o_TX_Serial); end
  endtask

  task automatic test_rotating();
    clear_q();
    pulse_start(2'b10, 8'h81, 3'd1);
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    push(8'h00, 1'b1);
    wait_rx(3, "rotate");
    idle_wait();
    check_frames("rotate", '{8'h81, 8'h03, 8'h06});
    ncomp++; if (done_cyc.size() !== 1) begin nfail++; $display("FAIL rotate_done_count: got %0d required 1", done_cyc.size()); end
  endtask

  task automatic test_chained();
    clear_q();
    pulse_start(2'b11, 8'h5A, 3'd0);
    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    pulse_start(2'b11, 8'h5A, 3'd0);
    push(8'h00, 1'b0);
    wait_rx(3, "chain");
    idle_wait();
    check_frames("chain", '{8'h5A, 8'hA5, 8'h5A});
  endtask

  task automatic test_back_to_back();
    logic [7:0] bp[7];
    int nacc;
    int k;
    bp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    clear_q();
    pulse_start(2'b00, 8'h00, 3'd0);
    i_Data_Valid = 1'b1; i_Last = 1'b0; i_Data = bp[0]; nacc = 0;
    for (int n = 0; n < 6; n++) begin
      if (!o_Data_Ready) break;
      tick();
      nacc++;
      i_Data = bp[nacc];
    end
    ncomp++; if (nacc !== 5) begin nfail++; $display("FAIL bp_accepted: got %0d required 5", nacc); end
    ncomp++; if (o_Fifo_Count !== 3'd4) begin nfail++; $display("FAIL bp_full_count: got %0d required 4", o_Fifo_Count); end
    i_Data = bp[5];
    k = 0;
    while (!o_Data_Ready && k < 200) begin tick(); k++; end
    ncomp++; if (k !== 10 * CPB - 2) begin nfail++; $display("FAIL bp_ready_low_cycles: got %0d required %0d", k, 10 * CPB - 2); end
    ncomp++; if (o_TX_Serial !== 1'b0) begin nfail++; $display("FAIL bp_reassert_start: got %b required 0", o_TX_Serial); end
    ncomp++; if (o_Fifo_Count !== 3'd3) begin nfail++; $display("FAIL bp_reassert_count: got %0d required 3", o_Fifo_Count); end
    tick();
    i_Data_Valid = 1'b0;
    wait_rx(6, "bp");
    idle_wait();
    check_frames("bp", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    ncomp++; if (done_cyc.size() !== 0) begin nfail++; $display("FAIL bp_no_done: got %0d required 0", done_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_q();
    pulse_start(2'b10, 8'h81, 3'd1);
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    push(8'h00, 1'b1);
    k = 0;
    while (rx_start.size() < 2 && k < 2000) begin tick(); k++; end
    repeat (3 * CPB) tick();
    i_Reset = 1'b1;
    tick();
    ncomp++; if (o_TX_Serial !== 1'b1) begin nfail++; $display("FAIL rmid_serial: got %b required 1", o_TX_Serial); end
    ncomp++; if (o_TX_Active !== 1'b0) begin nfail++; $display("FAIL rmid_active: got %b required 0", o_TX_Active); end
    ncomp++; if (o_Fifo_Count !== 3'd0) begin nfail++; $display("FAIL rmid_count: got %0d required 0", o_Fifo_Count); end
    ncomp++; if (dut.r_kw !== 8'h00) begin nfail++; $display("FAIL rmid_kw: got %02h required 00", dut.r_kw); end
    i_Reset = 1'b0;
    repeat (12 * CPB) tick();
    ncomp++; if (done_cyc.size() !== 0) begin nfail++; $display("FAIL rmid_no_done: got %0d required 0", done_cyc.size()); end
    ncomp++; if (rx_start.size() !== 2) begin nfail++; $display("FAIL rmid_frames: got %0d required 2", rx_start.size()); end
    ncomp++; if (rx_data.size() !== 1) begin nfail++; $display("FAIL rmid_complete: got %0d required 1", rx_data.size()); end
    check_frames("rmid", '{8'h81});
  endtask

  task automatic test_bypass();
    clear_q();
    pulse_start(2'b00, 8'hC3, 3'd5);
    push(8'h55, 1'b0);
    push(8'hA3, 1'b0);
    wait_rx(2, "bypass");
    idle_wait();
    check_frames("bypass", '{8'h55, 8'hA3});
    ncomp++;
    if (rx_start.size() < 2) begin
      nfail++; $display("FAIL bypass_spacing: got %0d starts required 2", rx_start.size());
    end else if (rx_start[1] - rx_start[0] !== 10 * CPB + 1) begin
      nfail++; $display("FAIL bypass_spacing: got %0d required %0d", rx_start[1] - rx_start[0], 10 * CPB + 1);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_rotating();
    test_chained();
    test_back_to_back();
    test_reset_mid();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/cipher_uart_tx.md
# cipher_uart_tx

Streaming encrypt-and-transmit block: accepts plaintext bytes over a valid/ready handshake and encrypts each byte with one of four selectable key modes. Ciphertext is buffered in a parametrised FIFO and serialised as 8N1 UART frames. It generalises the single-shot XOR encrypter plus UART transmitter pairing. It adds a key schedule (rotating and chained modes), buffering, back-pressure, and an end-of-message indication. It sits between the byte source (host logic or a UART receiver) and the serial TX pin.

## Interface
- CLKS_PER_BIT, 217, clocks per UART bit (25 MHz / 115200); must be ≥ 2
- FIFO_DEPTH, 16, ciphertext FIFO entries; power of 2, ≥ 2
- i_Clock  in  1  system clock, all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Start  in  1  one-cycle pulse: capture i_Mode, i_Key, i_Shift; reload working key
- i_Mode  in  2  00 bypass, 01 static XOR, 10 rotating XOR, 11 chained XOR
- i_Key  in  8  key, sampled only on i_Start
- i_Shift  in  3  left-rotate amount for mode 10, sampled only on i_Start
- i_Data_Valid  in  1  plaintext byte valid
- i_Data  in  8  plaintext byte
- i_Last  in  1  marks final byte of message, qualified by i_Data_Valid
- o_Data_Ready  out  1  FIFO can accept; equals !full and !i_Reset
- o_TX_Serial  out  1  UART line, idle high
- o_TX_Active  out  1  high while a frame (start..stop) is on the line
- o_Done  out  1  one-cycle pulse at end of stop bit of a byte tagged last
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Registers: M (mode), K0 (captured key), S (captured shift), Kw (working key).
- Reset values: M=00, K0=Kw=0, S=0, FIFO empty, TX FSM IDLE.
- Reset output values: o_TX_Serial=1, o_TX_Active=0, o_Done=0, o_Fifo_Count=0.
- i_Start: M<=i_Mode, K0<=i_Key, S<=i_Shift, Kw<=i_Key.
- Start coinciding with an accepted byte: the byte is encrypted with the old M/Kw, and Start's load wins over the Kw update.
- Accept = i_Data_Valid & o_Data_Ready. The ciphertext c is computed combinationally from i_Data and the current Kw. {i_Last, c} is written to the FIFO on the same edge.
  - 00: c = d; Kw unchanged.
  - 01: c = d ^ K0; Kw unchanged.
  - 10: c = d ^ Kw; Kw <= rotl8(Kw, S). S=0 behaves as static.
  - 11: c = d ^ Kw; Kw <= c (ciphertext feedback).
- FIFO: 9-bit entries, circular pointers wrap at FIFO_DEPTH.
  - Simultaneous push and pop keeps the count unchanged.
  - No push when full: ready is low, and a same-cycle pop does not re-enable ready in that cycle.
  - No pop when empty.
  - An empty FIFO has no bypass path to TX.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_TX_Serial=1. If FIFO is non-empty, pop the head, load the shift register and last-flag, go to START.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive bits 0..7, LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles, then go to IDLE. o_Done pulses in the final STOP cycle if the last-flag is set.
  - o_TX_Active=1 in START/DATA/STOP.
- i_Reset mid-frame: on the next edge the line goes high and active drops. The FIFO is flushed, the current frame is aborted without o_Done, and the key state returns to reset values.

## Timing
- Latency: a byte accepted at edge E with FIFO empty and TX idle is popped at edge E+1. The start bit is driven from E+1.
- Frame length: 10·CLKS_PER_BIT cycles.
- Back-to-back frame start spacing: 10·CLKS_PER_BIT+1 cycles, because of one IDLE cycle per byte.
- o_Data_Ready and o_Fifo_Count reflect registered state; Kw updates on the accept edge.
- o_Done is asserted for exactly one cycle, coincident with the last STOP cycle; the line is idle high on the next cycle.

## Test plan
- Mode 01, key 0x80, single byte 0x61 with i_Last=1; sample the line at mid-bit. Required: frame data 0xE1, then o_Done for 1 cycle, then o_TX_Active=0.
- Mode 10, key 0x81, shift 1, three bytes 0x00. Required: ciphertexts 0x81, 0x03, 0x06 in order.
- Mode 11, key 0x5A, bytes 0x00 then 0xFF. Required: 0x5A then 0xA5. A mid-stream i_Start with key 0x5A restarts the sequence at 0x5A.
- FIFO_DEPTH=4, CLKS_PER_BIT=4, valid held high continuously. Required: 5 bytes accepted before ready drops (1 popped, 4 buffered). All bytes appear on the line in order; ready reasserts the cycle after the next pop.
- Reset asserted in DATA of byte 2 of 3. Required: line high and active low the next cycle, o_Fifo_Count=0, no o_Done, Kw=0.
- Bypass mode, 2 queued bytes 0x55, 0xA3. Required: start bits 10·CLKS_PER_BIT+1 cycles apart, data matches plaintext.
